// File: rtl/sd_pp_generator.sv
// Radix-10 signed-digit partial-product generator.
// Latches a BCD multiplicand, builds 1X..5X in BCD during a single PRE cycle,
// then turns each one-hot recoded multiplier digit into one signed partial
// product (9's complement plus a hot-one flag for negative digits).

// One BCD digit adder cell; chained per digit to form multi-digit adders.
module sd_bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] raw;

  // Binary add, then fold anything above 9 back into 0..9 with a carry out.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    co  = (raw > 5'd9);
    s   = co ? 4'(raw - 5'd10) : raw[3:0];
  end
endmodule

module sd_pp_generator #(
  parameter int NX = 4,
  parameter int NY = 4,
  localparam int ND = NX + 1,
  localparam int IW = $clog2(NY + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4*NX-1:0] x_bcd,
  output logic            busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            y5,
  input  logic            y4,
  input  logic            y3,
  input  logic            y2,
  input  logic            y1,
  input  logic            ys,
  output logic            pp_valid,
  input  logic            pp_ready,
  output logic [4*ND-1:0] pp,
  output logic            pp_neg,
  output logic [IW-1:0]   pp_idx,
  output logic            pp_last,
  output logic            done,
  output logic            err
);
  typedef enum logic [1:0] {IDLE, PRE, RUN} state_t;
  typedef logic [ND-1:0][3:0] bcd_t;

  state_t          state_q, state_d;
  logic [4*NX-1:0] x_q, x_d;
  bcd_t            m1_q, m1_d, m2_q, m2_d, m3_q, m3_d, m4_q, m4_d, m5_q, m5_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            all_in_q, all_in_d;   // digit NY already taken; stop accepting
  logic            pp_valid_q, pp_valid_d;
  bcd_t            pp_q, pp_d;
  logic            pp_neg_q, pp_neg_d;
  logic [IW-1:0]   pp_idx_q, pp_idx_d;
  logic            pp_last_q, pp_last_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Multiple generation: 2X=X+X, 4X=2X+2X, 3X=2X+X, 5X=4X+X.
  bcd_t        x_ext, m2_c, m3_c, m4_c, m5_c;
  logic [ND:0] c2, c3, c4, c5;
  logic        unused_co;

  assign x_ext     = bcd_t'({4'h0, x_q});
  assign c2[0]     = 1'b0;
  assign c3[0]     = 1'b0;
  assign c4[0]     = 1'b0;
  assign c5[0]     = 1'b0;
  assign unused_co = c2[ND] | c3[ND] | c4[ND] | c5[ND];

  for (genvar g = 0; g < ND; g++) begin : g_dig
    sd_bcd_digit_add u_m2 (.a(x_ext[g]), .b(x_ext[g]), .ci(c2[g]), .s(m2_c[g]), .co(c2[g+1]));
    sd_bcd_digit_add u_m4 (.a(m2_c[g]),  .b(m2_c[g]),  .ci(c4[g]), .s(m4_c[g]), .co(c4[g+1]));
    sd_bcd_digit_add u_m3 (.a(m2_c[g]),  .b(x_ext[g]), .ci(c3[g]), .s(m3_c[g]), .co(c3[g+1]));
    sd_bcd_digit_add u_m5 (.a(m4_c[g]),  .b(x_ext[g]), .ci(c5[g]), .s(m5_c[g]), .co(c5[g+1]));
  end

  // Digit decode: highest set magnitude wins; more than one bit flags an error.
  logic [4:0] hot;
  logic       multi, nz, neg;
  bcd_t       sel, sel_signed;

  always_comb begin
    hot   = {y5, y4, y3, y2, y1};
    multi = (hot & (hot - 5'd1)) != 5'd0;
    nz    = |hot;
    neg   = ys & nz;   // -0 collapses to +0
    if (y5)      sel = m5_q;
    else if (y4) sel = m4_q;
    else if (y3) sel = m3_q;
    else if (y2) sel = m2_q;
    else if (y1) sel = m1_q;
    else         sel = '0;
    for (int i = 0; i < ND; i++)
      sel_signed[i] = neg ? (4'd9 - sel[i]) : sel[i];
  end

  logic accept;
  assign in_ready = (state_q == RUN) && !all_in_q && (!pp_valid_q || pp_ready);
  assign accept   = in_valid && in_ready;

  // Next-state logic: FSM sequencing plus output register load/hold.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    m1_d       = m1_q;
    m2_d       = m2_q;
    m3_d       = m3_q;
    m4_d       = m4_q;
    m5_d       = m5_q;
    idx_d      = idx_q;
    all_in_d   = all_in_q;
    pp_valid_d = pp_valid_q;
    pp_d       = pp_q;
    pp_neg_d   = pp_neg_q;
    pp_idx_d   = pp_idx_q;
    pp_last_d  = pp_last_q;
    done_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE: if (start) begin
        x_d      = x_bcd;
        err_d    = 1'b0;
        all_in_d = 1'b0;
        state_d  = PRE;
      end
      PRE: begin
        m1_d    = x_ext;
        m2_d    = m2_c;
        m3_d    = m3_c;
        m4_d    = m4_c;
        m5_d    = m5_c;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (pp_valid_q && pp_ready) begin
          pp_valid_d = 1'b0;
          if (pp_last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        if (accept) begin
          pp_valid_d = 1'b1;
          pp_d       = sel_signed;
          pp_neg_d   = neg;
          pp_idx_d   = idx_q;
          pp_last_d  = (idx_q == IW'(NY));
          all_in_d   = (idx_q == IW'(NY));
          idx_d      = idx_q + 1'b1;
          if (multi) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset discards any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      m1_q       <= '0;
      m2_q       <= '0;
      m3_q       <= '0;
      m4_q       <= '0;
      m5_q       <= '0;
      idx_q      <= '0;
      all_in_q   <= 1'b0;
      pp_valid_q <= 1'b0;
      pp_q       <= '0;
      pp_neg_q   <= 1'b0;
      pp_idx_q   <= '0;
      pp_last_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      m1_q       <= m1_d;
      m2_q       <= m2_d;
      m3_q       <= m3_d;
      m4_q       <= m4_d;
      m5_q       <= m5_d;
      idx_q      <= idx_d;
      all_in_q   <= all_in_d;
      pp_valid_q <= pp_valid_d;
      pp_q       <= pp_d;
      pp_neg_q   <= pp_neg_d;
      pp_idx_q   <= pp_idx_d;
      pp_last_q  <= pp_last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign pp_valid = pp_valid_q;
  assign pp       = pp_q;
  assign pp_neg   = pp_neg_q;
  assign pp_idx   = pp_idx_q;
  assign pp_last  = pp_last_q;
  assign done     = done_q;
  assign err      = err_q;
endmodule

// File: doc/sd_pp_generator.md
Name: sd_pp_generator

Overview:
- Digit-serial partial-product generator directly downstream of the BCD-to-SD radix-10 multiplier recoder.
- Latches the BCD multiplicand X on start and precomputes the odd and even multiples 1X..5X in BCD.
- Then accepts one recoded multiplier digit per handshake (one-hot magnitude y1..y5 plus sign ys) and emits the signed partial product for that digit toward the reduction tree.

Parameters:
- NX, 4, multiplicand digits.
- NY, 4, multiplier BCD digits; the block consumes NY+1 recoded digits, the extra top digit being the final carry.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  load multiplicand; honoured only in IDLE.
- x_bcd  in  4*NX  multiplicand, BCD, digit 0 in bits [3:0].
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  recoded digit present.
- in_ready  out  1  block accepts digit.
- y5, y4, y3, y2, y1  in  1 each  one-hot magnitude; all zero = 0.
- ys  in  1  digit negative.
- pp_valid  out  1  partial product valid.
- pp_ready  in  1  consumer accepts.
- pp  out  4*(NX+1)  partial product, BCD, NX+1 digits.
- pp_neg  out  1  pp is the 9's complement; consumer adds the +1 hot-one.
- pp_idx  out  ceil(log2(NY+1))  weight of pp (multiplier digit position).
- pp_last  out  1  pp_idx == NY.
- done  out  1  one-cycle pulse after the last pp handshake.
- err  out  1  sticky; set on a one-hot violation, cleared by an accepted start.

Behaviour:
- Reset (rst=1 at a clock edge) puts the block in IDLE and clears all outputs and counters: busy, in_ready, pp_valid, pp, pp_neg, pp_idx, pp_last, done and err are all 0. Reset mid-operation aborts; a partially output sequence is discarded.
- FSM states: IDLE, PRE, RUN.
  - IDLE: start=1 latches x_bcd and clears err; next state PRE.
  - PRE (exactly 1 cycle): registers M1=X, M2..M5 = 2X..5X as NX+1-digit BCD with decimal carry propagation; max 5*(10^NX - 1) fits. Next state RUN; idx=0.
  - RUN: in_ready = !pp_valid || pp_ready. The handshake in_valid && in_ready loads the output register on the same edge (latency 1 cycle) and sets pp_idx=idx; idx then increments.
  - Accepting the digit with idx==NY sets pp_last. The pp handshake with pp_last=1 returns the FSM to IDLE and pulses done in the next cycle.
- start outside IDLE is ignored; x_bcd is sampled only at acceptance.
- Selection: |d| = k where yk=1 selects Mk; all-zero selects 0.
- Sign rule:
  - ys=1 with k>0: pp = digitwise 9's complement of Mk over NX+1 digits, pp_neg=1.
  - k=0: pp=0, pp_neg=0 regardless of ys (the −0 case from Yi=9, yspi=1).
- Multiple y bits high: select the highest k, set err (sticky); processing continues.
- Output hold: pp, pp_neg, pp_idx and pp_last are held stable while pp_valid && !pp_ready. pp_valid drops after a handshake unless a new digit is accepted in the same cycle (back-to-back throughput of 1 per cycle).
- in_valid outside RUN is ignored; in_ready=0 there.

Test Plan:
- Reset, then start with x_bcd=0x1234 → busy=1 the next cycle; after 1 PRE cycle, in_ready=1. Multiples internally M2=02468, M3=03702, M4=04936, M5=06170.
- X=1234; send 5 digits, pp_ready=1: (y1,ys=0), (y3,ys=1), (y5,ys=0), (none,ys=1), (y2,ys=0) → pp = 0x01234 (neg 0), 0x96297 (neg 1), 0x06170 (neg 0), 0x00000 (neg 0), 0x02468 (neg 0). pp_idx = 0..4; pp_last on idx 4; done pulses 1 cycle after.
- X=9999, digit y5, ys=0 → pp = 0x49995. Same digit with ys=1 → pp = 0x50004, pp_neg=1.
- Back-pressure: hold pp_ready=0 for 3 cycles after the first pp → in_ready=0, pp stable. Release → the next digit is accepted in the same cycle; no digit is lost or duplicated.
- Digit with y2=y4=1 → pp = 4X, err=1 and held; the next accepted start clears err.
- Assert rst mid-RUN at idx=2 → the next cycle is IDLE with all outputs 0. A new start with X=0001 and digit y1 → pp = 0x00001.
